// File: rtl/mdu_if.sv
// Operand/result bundle between the execute-stage controller and the multiply/divide unit.
// The controller (master) drives requests and the rd_hi select; the unit (slave) returns HI/LO/out/busy.
interface mdu_if;
    // Handshake: start is a single-cycle request sampled on posedge. It is accepted only
    // when busy is 0 at that edge. There is no ready or queue: a request made while busy
    // is dropped, so the controller must hold off every MD instruction until busy reads 0.
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        rd_hi;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] out;
    logic        dbg_state;

    modport master (
        output start, op, A, B, rd_hi,
        input  busy, HI, LO, out, dbg_state
    );

    modport slave (
        input  start, op, A, B, rd_hi,
        output busy, HI, LO, out, dbg_state
    );
endinterface

// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers: MULT/MULTU/DIV/DIVU run for a fixed
// number of cycles, MTHI/MTLO write immediately, out muxes HI or LO for MFHI/MFLO.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic  clk,
    input  logic  rst,
    mdu_if.slave  bus
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [31:0]    hi_q;
    logic [31:0]    lo_q;
    logic [63:0]    res_q;
    logic           wb_en_q;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] uq_mag;
    logic [31:0] ur_mag;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [31:0] quot_u;
    logic [31:0] rem_u;

    // Signed multiply as a 64x64 product of sign-extended operands, keeping the low 64 bits.
    assign prod_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
    assign prod_u = {32'h0, bus.A} * {32'h0, bus.B};

    // Signed divide via magnitudes, so 0x80000000 / -1 yields 0x80000000 rem 0 with no overflow trap.
    always_comb begin
        a_mag  = bus.A[31] ? (~bus.A + 32'd1) : bus.A;
        b_mag  = bus.B[31] ? (~bus.B + 32'd1) : bus.B;
        uq_mag = '0;
        ur_mag = '0;
        quot_u = '0;
        rem_u  = '0;
        if (bus.B != 32'h0) begin
            uq_mag = a_mag / b_mag;
            ur_mag = a_mag % b_mag;
            quot_u = bus.A / bus.B;
            rem_u  = bus.A % bus.B;
        end
        quot_s = (bus.A[31] ^ bus.B[31]) ? (~uq_mag + 32'd1) : uq_mag;
        rem_s  = bus.A[31] ? (~ur_mag + 32'd1) : ur_mag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            res_q   <= '0;
            wb_en_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            OP_MULT: begin
                                res_q   <= prod_s;
                                wb_en_q <= 1'b1;
                                cnt     <= MULT_LOAD;
                                state   <= S_BUSY;
                            end
                            OP_MULTU: begin
                                res_q   <= prod_u;
                                wb_en_q <= 1'b1;
                                cnt     <= MULT_LOAD;
                                state   <= S_BUSY;
                            end
                            OP_DIV: begin
                                res_q   <= {rem_s, quot_s};
                                wb_en_q <= (bus.B != 32'h0);
                                cnt     <= DIV_LOAD;
                                state   <= S_BUSY;
                            end
                            OP_DIVU: begin
                                res_q   <= {rem_u, quot_u};
                                wb_en_q <= (bus.B != 32'h0);
                                cnt     <= DIV_LOAD;
                                state   <= S_BUSY;
                            end
                            OP_MTHI: hi_q <= bus.A;
                            OP_MTLO: lo_q <= bus.A;
                            default: ;
                        endcase
                    end
                end
                S_BUSY: begin
                    // A divide by zero still occupies the full latency but leaves HI/LO alone.
                    if (cnt == '0) begin
                        state <= S_IDLE;
                        if (wb_en_q) begin
                            hi_q <= res_q[63:32];
                            lo_q <= res_q[31:0];
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = (state == S_BUSY);
    assign bus.dbg_state = state;
    assign bus.HI        = hi_q;
    assign bus.LO        = lo_q;
    assign bus.out       = bus.rd_hi ? hi_q : lo_q;
endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: directed cases with literal results plus random traffic, all checked
// every cycle against a timestamp-based transaction model of HI/LO/busy.
module tb_mdu;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk;
    logic rst;
    mdu_if bus();

    mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Result word: bit 64 says whether HI/LO get written, [63:32]=HI, [31:0]=LO.
    function automatic logic [64:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        int          sa;
        int          sb;
        int          q;
        int          r;
        sa = int'(a);
        sb = int'(b);
        case (o)
            3'd1: begin
                sp = longint'(sa) * longint'(sb);
                up = sp;
                return {1'b1, up};
            end
            3'd2: begin
                up = {32'h0, a} * {32'h0, b};
                return {1'b1, up};
            end
            3'd3: begin
                if (b == 32'h0) return {1'b0, 64'h0};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h0, 32'h8000_0000};
                q = sa / sb;
                r = sa % sb;
                return {1'b1, 32'(r), 32'(q)};
            end
            3'd4: begin
                if (b == 32'h0) return {1'b0, 64'h0};
                return {1'b1, a % b, a / b};
            end
            default: return '0;
        endcase
    endfunction

    int          cyc = 0;
    int          m_done = 0;
    logic        m_busy = 1'b0;
    logic        m_was_busy;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [64:0] m_res;
    logic [64:0] exp_q[$];

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_busy = 1'b0;
            m_hi   = '0;
            m_lo   = '0;
            exp_q.delete();
        end else begin
            m_was_busy = m_busy;
            if (m_was_busy && cyc == m_done) begin
                m_res = exp_q.pop_front();
                if (m_res[64]) begin
                    m_hi = m_res[63:32];
                    m_lo = m_res[31:0];
                end
                m_busy = 1'b0;
            end
            if (!m_was_busy && bus.start) begin
                case (bus.op)
                    3'd1, 3'd2: begin
                        exp_q.push_back(ref_result(bus.op, bus.A, bus.B));
                        m_busy = 1'b1;
                        m_done = cyc + MULT_N;
                    end
                    3'd3, 3'd4: begin
                        exp_q.push_back(ref_result(bus.op, bus.A, bus.B));
                        m_busy = 1'b1;
                        m_done = cyc + DIV_N;
                    end
                    3'd5: m_hi = bus.A;
                    3'd6: m_lo = bus.A;
                    default: ;
                endcase
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cyc > 0) begin
            check("cyc_busy", {31'h0, bus.busy}, {31'h0, m_busy});
            check("cyc_state", {31'h0, bus.dbg_state}, {31'h0, m_busy});
            check("cyc_hi", bus.HI, m_hi);
            check("cyc_lo", bus.LO, m_lo);
            check("cyc_out", bus.out, bus.rd_hi ? m_hi : m_lo);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = o;
        bus.A     = a;
        bus.B     = b;
        step();
        bus.start = 1'b0;
    endtask

    // Issue a long op and count busy cycles; inject=1 pulses MTLO and DIV while busy.
    task automatic run_long(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                            input int exp_len, input bit inject, input string nm);
        int n;
        issue(o, a, b);
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            if (inject && n == 1) begin
                bus.start = 1'b1; bus.op = 3'd6; bus.A = 32'h0000_ABCD;
            end else if (inject && n == 2) begin
                bus.start = 1'b1; bus.op = 3'd3; bus.A = 32'd9; bus.B = 32'd3;
            end else begin
                bus.start = 1'b0;
            end
            step();
        end
        bus.start = 1'b0;
        check(nm, n, exp_len);
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            step();
        end
        check(nm, {31'h0, bus.busy}, 32'h0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.A     = '0;
        bus.B     = '0;
        bus.rd_hi = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("reset_busy", {31'h0, bus.busy}, 32'h0);
        check("reset_hi", bus.HI, 32'h0);
        check("reset_lo", bus.LO, 32'h0);

        // T1 MULT -3 * 5
        bus.rd_hi = 1'b1;
        run_long(3'd1, 32'hFFFF_FFFD, 32'd5, MULT_N, 1'b0, "t1_busy_len");
        check("t1_hi", bus.HI, 32'hFFFF_FFFF);
        check("t1_lo", bus.LO, 32'hFFFF_FFF1);
        check("t1_out_hi", bus.out, 32'hFFFF_FFFF);
        bus.rd_hi = 1'b0;
        #1;
        check("t1_out_lo", bus.out, 32'hFFFF_FFF1);
        check("t1_model_lo", m_lo, 32'hFFFF_FFF1);

        // T2 MULTU
        run_long(3'd2, 32'hFFFF_FFFF, 32'd2, MULT_N, 1'b0, "t2_busy_len");
        check("t2_hi", bus.HI, 32'h0000_0001);
        check("t2_lo", bus.LO, 32'hFFFF_FFFE);

        // T3 DIV / DIVU
        run_long(3'd3, 32'hFFFF_FFF9, 32'd2, DIV_N, 1'b0, "t3_div_busy_len");
        check("t3_div_lo", bus.LO, 32'hFFFF_FFFD);
        check("t3_div_hi", bus.HI, 32'hFFFF_FFFF);
        check("t3_model_hi", m_hi, 32'hFFFF_FFFF);
        run_long(3'd4, 32'd7, 32'd2, DIV_N, 1'b0, "t3_divu_busy_len");
        check("t3_divu_lo", bus.LO, 32'd3);
        check("t3_divu_hi", bus.HI, 32'd1);

        // Signed overflow corner
        run_long(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N, 1'b0, "ovf_busy_len");
        check("ovf_lo", bus.LO, 32'h8000_0000);
        check("ovf_hi", bus.HI, 32'h0);

        // T4 divide by zero keeps preloaded HI/LO
        issue(3'd5, 32'h11, 32'h0);
        issue(3'd6, 32'h22, 32'h0);
        check("t4_mthi", bus.HI, 32'h11);
        check("t4_mtlo", bus.LO, 32'h22);
        run_long(3'd4, 32'd7, 32'd0, DIV_N, 1'b0, "t4_busy_len");
        check("t4_hi", bus.HI, 32'h11);
        check("t4_lo", bus.LO, 32'h22);

        // T5 starts while busy are dropped
        run_long(3'd1, 32'd3, 32'd4, MULT_N, 1'b1, "t5_busy_len");
        check("t5_hi", bus.HI, 32'h0);
        check("t5_lo", bus.LO, 32'd12);
        step();
        check("t5_no_late_div", {31'h0, bus.busy}, 32'h0);

        // Back-to-back: held start is taken only once busy reads 0
        issue(3'd1, 32'd2, 32'd3);
        bus.start = 1'b1; bus.op = 3'd4; bus.A = 32'd100; bus.B = 32'd7;
        wait_idle("b2b_first_done");
        check("b2b_first_lo", bus.LO, 32'd6);
        step();
        bus.start = 1'b0;
        check("b2b_second_busy", {31'h0, bus.busy}, 32'h1);
        wait_idle("b2b_second_done");
        check("b2b_lo", bus.LO, 32'd14);
        check("b2b_hi", bus.HI, 32'd2);

        // T6 reset mid-DIV
        issue(3'd3, 32'd100, 32'd3);
        step();
        rst = 1'b1;
        step();
        check("t6_busy", {31'h0, bus.busy}, 32'h0);
        check("t6_hi", bus.HI, 32'h0);
        check("t6_lo", bus.LO, 32'h0);
        rst = 1'b0;
        repeat (15) step();
        check("t6_late_hi", bus.HI, 32'h0);
        check("t6_late_lo", bus.LO, 32'h0);

        // Random traffic, including starts while busy and occasional reset
        for (int i = 0; i < 600; i++) begin
            bus.start = ($urandom_range(0, 2) == 0);
            bus.op    = 3'($urandom_range(0, 7));
            bus.A     = $urandom();
            bus.B     = $urandom();
            case ($urandom_range(0, 9))
                0: bus.B = 32'h0;
                1: begin bus.A = 32'h8000_0000; bus.B = 32'hFFFF_FFFF; end
                2: bus.B = 32'($urandom_range(1, 16));
                default: ;
            endcase
            bus.rd_hi = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0;
        bus.start = 1'b0;
        step();
        wait_idle("rand_drain");
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
